// File: rtl/programmable_clock_divider.sv
// Multi-channel runtime-programmable clock divider: per-channel period/high time,
// shadowed config applied at period boundaries so reconfiguration never produces runt pulses.

module programmable_clock_divider_ch #(
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 6,
    parameter int DEFAULT_HIGH   = 3
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wr_period,
    input  logic [CNT_WIDTH-1:0] wr_high,
    output logic                 clk_out,
    output logic                 tick
);
    logic [CNT_WIDTH-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
    logic [CNT_WIDTH-1:0] shd_p_q, shd_h_q, cnt_q, cnt_d;
    logic                 pend_q, run_q, clk_out_q, tick_q;
    logic                 start, boundary, apply;

    // The first enabled cycle after idle is also a period start, so a shadow
    // written in the last idle cycle is picked up there rather than a period late.
    always_comb begin
        start    = en && !run_q;
        boundary = en && run_q && (cnt_q == act_p_q - CNT_WIDTH'(1));
        apply    = pend_q && (!en || boundary || start);
        act_p_d  = apply ? shd_p_q : act_p_q;
        act_h_d  = apply ? shd_h_q : act_h_q;
        cnt_d    = '0;
        if (en && run_q && !boundary)
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            act_p_q   <= CNT_WIDTH'(DEFAULT_PERIOD);
            act_h_q   <= CNT_WIDTH'(DEFAULT_HIGH);
            shd_p_q   <= '0;
            shd_h_q   <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            act_p_q   <= act_p_d;
            act_h_q   <= act_h_d;
            cnt_q     <= cnt_d;
            run_q     <= en;
            clk_out_q <= en && (cnt_d < act_h_d);
            tick_q    <= en && (cnt_d == '0);
            // A write landing in an apply cycle stays pending for the next boundary.
            if (wr) begin
                shd_p_q <= wr_period;
                shd_h_q <= wr_high;
                pend_q  <= 1'b1;
            end else if (apply) begin
                pend_q  <= 1'b0;
            end
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
endmodule

module programmable_clock_divider #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 6,
    parameter int DEFAULT_HIGH   = 3,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick
);
    logic              cfg_ready_q, cfg_err_q;
    logic              accept, bad, cfg_ok;
    logic [NUM_CH-1:0] wr;

    assign accept = cfg_valid && cfg_ready_q;
    assign bad    = (cfg_period < CNT_WIDTH'(2)) ||
                    ({{(32-CH_W){1'b0}}, cfg_ch} >= 32'(NUM_CH));
    assign cfg_ok = accept && !bad;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= accept && bad;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_ok && (cfg_ch == CH_W'(i));
        programmable_clock_divider_ch #(
            .CNT_WIDTH     (CNT_WIDTH),
            .DEFAULT_PERIOD(DEFAULT_PERIOD),
            .DEFAULT_HIGH  (DEFAULT_HIGH)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en[i]),
            .wr       (wr[i]),
            .wr_period(cfg_period),
            .wr_high  (cfg_high),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed scoreboard bench: the stimulus process queues the expected outputs of each
// cycle from hand-chosen per-channel schedules; a monitor pops and compares on negedge.

module tb_programmable_clock_divider;
    localparam int NCH = 3;   // three channels so cfg_ch=3 is an encodable out-of-range index
    localparam int W   = 16;

    logic           clk_in = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [W-1:0]   cfg_period = '0;
    logic [W-1:0]   cfg_high = '0;
    logic           cfg_err;
    logic [NCH-1:0] clk_out, tick;

    programmable_clock_divider #(
        .NUM_CH(NCH), .CNT_WIDTH(W), .DEFAULT_PERIOD(6), .DEFAULT_HIGH(3)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int             j;
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
        logic           err;
        logic           rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected record per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 4;
                if (clk_out !== e.co) begin errors++; $display("FAIL clk_out j=%0d got %b exp %b", e.j, clk_out, e.co); end
                if (tick !== e.tk)    begin errors++; $display("FAIL tick j=%0d got %b exp %b", e.j, tick, e.tk); end
                if (cfg_err !== e.err) begin errors++; $display("FAIL cfg_err j=%0d got %b exp %b", e.j, cfg_err, e.err); end
                if (cfg_ready !== e.rdy) begin errors++; $display("FAIL cfg_ready j=%0d got %b exp %b", e.j, cfg_ready, e.rdy); end
            end
        end
    end

    task automatic cyc(input logic r, input logic [NCH-1:0] e, input logic v, input logic [1:0] ch,
                       input logic [W-1:0] p, input logic [W-1:0] h, input exp_t x);
        rst = r; en = e; cfg_valid = v; cfg_ch = ch; cfg_period = p; cfg_high = h;
        q.push_back(x);
        @(posedge clk_in);
        #1;
    endtask

    // Per-channel expected schedule: period start cycle, period, high time, enabled.
    int st[NCH], pp[NCH], hh[NCH];
    bit on[NCH];

    initial begin
        exp_t x;
        logic [NCH-1:0] e_in;
        logic v, r;
        logic [1:0] ch;
        logic [W-1:0] p, h;
        int ph;

        // Reset: two cycles in reset, then one idle cycle with the port ready.
        x = '{j: -3, co: '0, tk: '0, err: 1'b0, rdy: 1'b0};
        cyc(1'b1, '0, 1'b0, 2'd0, '0, '0, x);
        x.j = -2;
        cyc(1'b1, '0, 1'b0, 2'd0, '0, '0, x);
        x.j = -1; x.rdy = 1'b1;
        cyc(1'b0, '0, 1'b0, 2'd0, '0, '0, x);

        for (int c = 0; c < NCH; c++) begin st[c] = 0; pp[c] = 6; hh[c] = 3; on[c] = 1'b1; end

        for (int j = 0; j <= 84; j++) begin
            r = 1'b0; e_in = '1; v = 1'b0; ch = 2'd0; p = '0; h = '0;
            x = '{j: j, co: '0, tk: '0, err: 1'b0, rdy: 1'b1};
            case (j)
                15: begin v = 1; ch = 1; p = 4; h = 1; end           // ch1 at cnt=2
                18: begin st[1] = 18; pp[1] = 4; hh[1] = 1; end
                24: begin v = 1; ch = 0; p = 5; h = 0; end           // lands on ch0 boundary
                25: begin v = 1; ch = 2; p = 5; h = 10; end
                30: begin st[0] = 30; pp[0] = 5; hh[0] = 0; st[2] = 30; pp[2] = 5; hh[2] = 10; end
                41: begin v = 1; ch = 1; p = 1; h = 0; x.err = 1'b1; end
                42: begin v = 1; ch = 3; p = 7; h = 2; x.err = 1'b1; end
                46: begin v = 1; ch = 0; p = 3; h = 3; end
                47: begin v = 1; ch = 0; p = 4; h = 2; end
                50: begin st[0] = 50; pp[0] = 4; hh[0] = 2; end
                58: begin v = 1; ch = 2; p = 3; h = 1; end
                59, 60: begin e_in = 3'b011; on[2] = 1'b0; end
                61: begin on[2] = 1'b1; st[2] = 61; pp[2] = 3; hh[2] = 1; end
                67: begin v = 1; ch = 1; p = 7; h = 7; end
                68: begin r = 1; v = 1; ch = 0; p = 2; h = 1; end
                69, 70: r = 1;
                71: for (int c = 0; c < NCH; c++) begin st[c] = 71; pp[c] = 6; hh[c] = 3; end
                default: ;
            endcase
            if (r) begin
                x.rdy = 1'b0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (on[c]) begin
                        ph = (j - st[c]) % pp[c];
                        x.co[c] = (ph < hh[c]);
                        x.tk[c] = (ph == 0);
                    end
                end
            end
            cyc(r, e_in, v, ch, p, h, x);
        end

        v = 1'b0; cfg_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_in);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
